core_boot_sequencer: RTL

//  Boot/run controller for one RISC_V_Core. It holds the core in reset and streams a program

---
 rtl/core_boot_sequencer_if.sv | 13 +
 rtl/core_boot_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/core_boot_sequencer_if.sv
// Program-image load stream from the host/loader into the boot sequencer.
// master = loader side, slave = sequencer side.
interface core_boot_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;

    modport master (output load_valid, load_data, load_last, input load_ready);
    modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/core_boot_sequencer.sv
// Boot/run controller for one core: streams an image into instruction memory under reset,
// releases reset, pulses start at the entry PC, then supervises the run until halt or timeout.
module core_boot_sequencer #(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned ADDRESS_BITS         = 12,
    parameter int unsigned PROG_ADDR_BITS       = 20,
    parameter int unsigned RESET_RELEASE_CYCLES = 4,
    parameter int unsigned RUN_CYCLES           = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      boot_req,
    input  logic [PROG_ADDR_BITS-1:0] boot_address,
    input  logic                      abort,
    core_boot_sequencer_if.slave      load,
    output logic                      isp_write,
    output logic [ADDRESS_BITS-1:0]   isp_address,
    output logic [DATA_WIDTH-1:0]     isp_data,
    output logic                      core_reset,
    output logic                      start,
    output logic [PROG_ADDR_BITS-1:0] prog_address,
    input  logic                      halt,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                status,
    output logic [ADDRESS_BITS:0]     words_loaded
);
    localparam int unsigned WL_W     = ADDRESS_BITS + 1;
    localparam int unsigned REL_W    = (RESET_RELEASE_CYCLES > 1) ? $clog2(RESET_RELEASE_CYCLES) : 1;
    localparam int unsigned RUN_W    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int unsigned REL_LAST = (RESET_RELEASE_CYCLES > 0) ? RESET_RELEASE_CYCLES - 1 : 0;
    localparam int unsigned RUN_LAST = (RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0;
    localparam logic [WL_W-1:0] MAX_ADDR = WL_W'((1 << ADDRESS_BITS) - 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_ABORTED  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [PROG_ADDR_BITS-1:0] boot_addr_q, boot_addr_nxt;
    logic [REL_W-1:0]          rel_cnt, rel_cnt_nxt;
    logic [RUN_W-1:0]          run_cnt, run_cnt_nxt;
    logic [WL_W-1:0]           words_nxt;
    logic [1:0]                status_nxt;
    logic                      isp_write_nxt;
    logic [ADDRESS_BITS-1:0]   isp_address_nxt;
    logic [DATA_WIDTH-1:0]     isp_data_nxt;
    logic [PROG_ADDR_BITS-1:0] prog_address_nxt;
    logic                      core_reset_nxt;
    logic                      start_nxt;
    logic                      busy_nxt;
    logic                      done_nxt;

    assign load.load_ready = (state == S_LOAD);

    // Next state plus next value of every registered output.
    always_comb begin
        state_nxt        = state;
        boot_addr_nxt    = boot_addr_q;
        rel_cnt_nxt      = rel_cnt;
        run_cnt_nxt      = run_cnt;
        words_nxt        = words_loaded;
        status_nxt       = status;
        isp_write_nxt    = 1'b0;
        isp_address_nxt  = isp_address;
        isp_data_nxt     = isp_data;
        prog_address_nxt = prog_address;

        if (abort && (state != S_IDLE)) begin
            state_nxt  = S_IDLE;
            status_nxt = ST_ABORTED;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (boot_req && !abort) begin
                        state_nxt     = S_LOAD;
                        boot_addr_nxt = boot_address;
                        words_nxt     = '0;
                        status_nxt    = ST_OK;
                    end
                end
                S_LOAD: begin
                    if (load.load_valid) begin
                        isp_write_nxt   = 1'b1;
                        isp_address_nxt = words_loaded[ADDRESS_BITS-1:0];
                        isp_data_nxt    = load.load_data;
                        words_nxt       = words_loaded + WL_W'(1);
                        if (load.load_last) begin
                            state_nxt   = S_RELEASE;
                            rel_cnt_nxt = '0;
                        end else if (words_loaded == MAX_ADDR) begin
                            // image would overrun memory; never wrap the address
                            state_nxt  = S_DONE;
                            status_nxt = ST_OVERFLOW;
                        end
                    end
                end
                S_RELEASE: begin
                    if (rel_cnt == REL_W'(REL_LAST)) begin
                        state_nxt        = S_START;
                        prog_address_nxt = boot_addr_q;
                    end else begin
                        rel_cnt_nxt = rel_cnt + REL_W'(1);
                    end
                end
                S_START: begin
                    state_nxt   = S_RUN;
                    run_cnt_nxt = '0;
                end
                S_RUN: begin
                    if (halt) begin
                        state_nxt  = S_DONE;
                        status_nxt = ST_OK;
                    end else if ((RUN_CYCLES != 0) && (run_cnt == RUN_W'(RUN_LAST))) begin
                        state_nxt  = S_DONE;
                        status_nxt = ST_TIMEOUT;
                    end else begin
                        run_cnt_nxt = run_cnt + RUN_W'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        core_reset_nxt = !((state_nxt == S_RELEASE) || (state_nxt == S_START) || (state_nxt == S_RUN));
        busy_nxt       = !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
        done_nxt       = (state_nxt == S_DONE);
        start_nxt      = (state_nxt == S_START);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            boot_addr_q  <= '0;
            rel_cnt      <= '0;
            run_cnt      <= '0;
            words_loaded <= '0;
            status       <= ST_OK;
            isp_write    <= 1'b0;
            isp_address  <= '0;
            isp_data     <= '0;
            prog_address <= '0;
            core_reset   <= 1'b1;
            start        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            boot_addr_q  <= boot_addr_nxt;
            rel_cnt      <= rel_cnt_nxt;
            run_cnt      <= run_cnt_nxt;
            words_loaded <= words_nxt;
            status       <= status_nxt;
            isp_write    <= isp_write_nxt;
            isp_address  <= isp_address_nxt;
            isp_data     <= isp_data_nxt;
            prog_address <= prog_address_nxt;
            core_reset   <= core_reset_nxt;
            start        <= start_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end
endmodule
